// File: rtl/univ_shift_reg_n_pkg.sv
// Shared constants for the universal shift register: operation encodings
// and burst-controller FSM states.
package shift_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_ROL  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_CLR  = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

endpackage

// File: rtl/univ_shift_reg_n_if.sv
// Control/data bundle of the universal shift register. The register has no
// ready backpressure: start is a request sampled only in IDLE, busy marks a
// burst in flight and done is a one-cycle completion pulse after busy falls.
interface univ_shift_reg_n_if #(parameter int WIDTH = 8);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] p_in;
   logic             serial_right;
   logic             serial_left;
   logic             start;
   logic [CNT_W-1:0] amount;
   logic [WIDTH-1:0] q;
   logic             so_r;
   logic             so_l;
   logic             busy;
   logic             done;

   modport master (
      output en, mode, p_in, serial_right, serial_left, start, amount,
      input  q, so_r, so_l, busy, done
   );

   modport slave (
      input  en, mode, p_in, serial_right, serial_left, start, amount,
      output q, so_r, so_l, busy, done
   );

endinterface

// File: rtl/univ_shift_reg_n_step.sv
// Combinational next-value function of the shift register; shared by single
// steps and burst steps.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic [WIDTH-1:0] i_q,
   input  logic [2:0]       i_mode,
   input  logic [WIDTH-1:0] i_p_in,
   input  logic             i_serial_right,
   input  logic             i_serial_left,
   output logic [WIDTH-1:0] o_next
);

   always_comb begin
      o_next = i_q;
      case (i_mode)
         MODE_HOLD: o_next = i_q;
         MODE_SHR:  o_next = {i_serial_right, i_q[WIDTH-1:1]};
         MODE_SHL:  o_next = {i_q[WIDTH-2:0], i_serial_left};
         MODE_LOAD: o_next = i_p_in;
         MODE_ROR:  o_next = {i_q[0], i_q[WIDTH-1:1]};
         MODE_ROL:  o_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
         MODE_ASR:  o_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
         MODE_CLR:  o_next = '0;
         default:   o_next = i_q;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg_n.sv
// Parametrised universal shift register with single-step operation and a
// start/busy/done controlled multi-cycle burst.
module univ_shift_reg_n
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   univ_shift_reg_n_if.slave bus,
   output state_t            o_state
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t           r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [2:0]       r_mode, w_mode_nx, w_step_mode;
   logic [WIDTH-1:0] r_q, w_q_nx, w_step;
   logic             r_done, w_done_nx;

   // A burst replays the latched mode; live mode only drives single steps.
   assign w_step_mode = (r_state == ST_BURST) ? r_mode : bus.mode;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .i_q            (r_q),
      .i_mode         (w_step_mode),
      .i_p_in         (bus.p_in),
      .i_serial_right (bus.serial_right),
      .i_serial_left  (bus.serial_left),
      .o_next         (w_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_mode  <= MODE_HOLD;
         r_q     <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_mode  <= w_mode_nx;
         r_q     <= w_q_nx;
         r_done  <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_mode_nx  = r_mode;
      w_q_nx     = r_q;
      w_done_nx  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               // A zero-length burst completes immediately without entering BURST.
               if (bus.amount != '0) begin
                  w_mode_nx  = bus.mode;
                  w_cnt_nx   = bus.amount;
                  w_state_nx = ST_BURST;
               end else begin
                  w_done_nx = 1'b1;
               end
            end else if (bus.en) begin
               w_q_nx = w_step;
            end
         end
         ST_BURST: begin
            if (bus.en) begin
               w_q_nx   = w_step;
               w_cnt_nx = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  w_state_nx = ST_IDLE;
                  w_done_nx  = 1'b1;
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.q    = r_q;
      bus.so_r = r_q[0];
      bus.so_l = r_q[WIDTH-1];
      bus.busy = (r_state == ST_BURST);
      bus.done = r_done;
      o_state  = r_state;
   end

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Self-checking bench for univ_shift_reg_n at WIDTH=8: single-step vector
// table, burst/stall/boundary sequences and reset abort.
module tb_univ_shift_reg_n;
   import shift_pkg::*;

   logic   clk;
   logic   rst_n;
   state_t dbg_state;

   univ_shift_reg_n_if #(.WIDTH(8)) bus ();

   univ_shift_reg_n #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .o_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [2:0] mode;
      logic [7:0] p_in;
      logic       sr;
      logic       sl;
      logic [7:0] exp_q;
   } vec_t;

   vec_t       vecs[10];
   logic [7:0] exp_q[$];
   logic [7:0] cur_q;
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [2:0] mode, input logic [7:0] p_in,
                        input logic sr, input logic sl, input logic start, input logic [3:0] amount);
      bus.en           = en;
      bus.mode         = mode;
      bus.p_in         = p_in;
      bus.serial_right = sr;
      bus.serial_left  = sl;
      bus.start        = start;
      bus.amount       = amount;
   endtask

   task automatic load(input logic [7:0] val);
      drive(1'b1, MODE_LOAD, val, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      cur_q = val;
      chk("load", bus.q, val);
   endtask

   // Drives a running burst to completion; mode/amount/start are scrambled
   // each cycle since BURST must ignore them.
   task automatic run_burst(input int stall_at, input int stall_len, input logic sr,
                            input logic sl, output int busy_cycles);
      int  applied;
      int  stalled;
      bit  stall;
      bit  finished;
      applied     = 0;
      stalled     = 0;
      busy_cycles = 0;
      finished    = 1'b0;
      for (int g = 0; g < 64; g++) begin
         if (!bus.busy) begin
            finished = 1'b1;
            break;
         end
         busy_cycles++;
         stall = (applied == stall_at) && (stalled < stall_len);
         bus.en           = !stall;
         bus.mode         = 3'($urandom_range(0, 7));
         bus.amount       = 4'($urandom_range(0, 15));
         bus.start        = 1'($urandom_range(0, 1));
         bus.serial_right = sr;
         bus.serial_left  = sl;
         tick();
         if (stall) begin
            stalled++;
            chk("stall_hold", bus.q, cur_q);
         end else begin
            applied++;
            if (exp_q.size() == 0) begin
               chk("burst_overrun", 1, 0);
            end else begin
               cur_q = exp_q.pop_front();
               chk("burst_q", bus.q, cur_q);
            end
         end
      end
      chk("burst_timeout", 32'(finished), 1);
      chk("burst_done", bus.done, 1);
      chk("done_busy_excl", bus.busy, 0);
      chk("exp_q_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int         busy_cycles;
      logic [7:0] e;
      logic [7:0] v;

      vecs[0] = '{1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5};
      vecs[1] = '{1'b1, MODE_SHR,  8'h00, 1'b1, 1'b0, 8'hD2};
      vecs[2] = '{1'b1, MODE_SHL,  8'hFF, 1'b1, 1'b0, 8'hA4};
      vecs[3] = '{1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0, 8'h80};
      vecs[4] = '{1'b1, MODE_ASR,  8'h00, 1'b0, 1'b0, 8'hC0};
      vecs[5] = '{1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0, 8'h60};
      vecs[6] = '{1'b1, MODE_ROL,  8'h00, 1'b1, 1'b1, 8'hC0};
      vecs[7] = '{1'b1, MODE_HOLD, 8'h11, 1'b1, 1'b1, 8'hC0};
      vecs[8] = '{1'b1, MODE_CLR,  8'h11, 1'b1, 1'b1, 8'h00};
      vecs[9] = '{1'b0, MODE_LOAD, 8'hFF, 1'b1, 1'b1, 8'h00};

      rst_n = 1'b0;
      drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
      repeat (2) tick();
      chk("rst_q", bus.q, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      tick();

      // Single-step vectors
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].en, vecs[i].mode, vecs[i].p_in, vecs[i].sr, vecs[i].sl, 1'b0, 4'd0);
         exp_q.push_back(vecs[i].exp_q);
         tick();
         e = exp_q.pop_front();
         chk($sformatf("step%0d_q", i), bus.q, e);
         chk($sformatf("step%0d_so_r", i), bus.so_r, e[0]);
         chk($sformatf("step%0d_so_l", i), bus.so_l, e[7]);
         chk($sformatf("step%0d_busy", i), bus.busy, 0);
      end

      // Burst ROL by 3, with en high at accept to check start priority
      load(8'h81);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h06);
      exp_q.push_back(8'h0C);
      drive(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
      tick();
      chk("rol_accept_q", bus.q, 8'h81);
      chk("rol_accept_busy", bus.busy, 1);
      run_burst(99, 0, 1'b0, 1'b0, busy_cycles);
      chk("rol_busy_cycles", busy_cycles, 3);
      chk("rol_final", bus.q, 8'h0C);
      drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      chk("rol_done_once", bus.done, 0);

      // Burst SHR by 4 with a 2-cycle stall after two steps
      load(8'hF0);
      exp_q.push_back(8'h78);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h1E);
      exp_q.push_back(8'h0F);
      drive(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4);
      tick();
      run_burst(2, 2, 1'b0, 1'b0, busy_cycles);
      chk("stall_busy_cycles", busy_cycles, 6);
      chk("stall_final", bus.q, 8'h0F);
      drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      chk("stall_done_once", bus.done, 0);

      // amount = 0: immediate done, no step, no busy
      load(8'h5A);
      drive(1'b1, MODE_CLR, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd0);
      tick();
      chk("amt0_q", bus.q, 8'h5A);
      chk("amt0_busy", bus.busy, 0);
      chk("amt0_done", bus.done, 1);
      drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      chk("amt0_done_once", bus.done, 0);

      // ROR by full width returns the original value
      load(8'h3C);
      v = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         v = {v[0], v[7:1]};
         exp_q.push_back(v);
      end
      drive(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8);
      tick();
      run_burst(99, 0, 1'b0, 1'b0, busy_cycles);
      chk("ror8_busy_cycles", busy_cycles, 8);
      chk("ror8_final", bus.q, 8'h3C);

      // New start accepted in the done cycle: SHL by 2 with serial_left=1
      exp_q.push_back(8'h79);
      exp_q.push_back(8'hF3);
      drive(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b1, 1'b1, 4'd2);
      tick();
      chk("redo_busy", bus.busy, 1);
      chk("redo_accept_q", bus.q, 8'h3C);
      run_burst(99, 0, 1'b0, 1'b1, busy_cycles);
      chk("redo_busy_cycles", busy_cycles, 2);
      chk("redo_final", bus.q, 8'hF3);
      drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();

      // Reset mid-burst aborts without a done pulse
      load(8'hA5);
      drive(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8);
      tick();
      drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
      chk("abort_pre_q", bus.q, 8'hA5);
      chk("abort_pre_busy", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_q", bus.q, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_no_done", bus.done, 0);
         chk("abort_idle", bus.busy, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
